// File: rtl/line_mem_pkg.sv
// Shared encodings for the line-memory arbiter: FSM states, requester sides,
// and default address/line widths.
package line_mem_pkg;

  localparam int AW_DEF = 12;
  localparam int LW_DEF = 256;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: a lone requester always wins, and a tie
// goes to the side named by prio.
module rr_arb2
  import line_mem_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_side
);

  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_side  = SIDE_I;
    if (req_i && req_d) gnt_side = prio;
    else if (req_d)     gnt_side = SIDE_D;
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// Shares one line-wide data memory between I-refill and D-cache traffic,
// sequencing each access over MEM_LAT cycles and holding the pipeline meanwhile.
module line_mem_arbiter
  import line_mem_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int LW      = LW_DEF,
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [LW-1:0] i_wdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [LW-1:0] d_wdata,
  output logic          d_ack,
  output logic [LW-1:0] rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [LW-1:0] mem_wdata,
  input  logic [LW-1:0] mem_rdata,
  output logic          clk_lock
);

  // state | meaning
  // IDLE  | no access in flight; arbitrate and latch the winner
  // BUSY  | access in flight; cnt counts down to the strobe/capture cycle
  // DONE  | one-cycle ack to the owner

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          prio;
  logic          owner;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [LW-1:0] lat_wdata;
  logic          gnt_valid;
  logic          gnt_side;
  logic          last_busy;

  rr_arb2 u_rr_arb2 (
    .req_i     (i_req),
    .req_d     (d_req),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_side  (gnt_side)
  );

  assign last_busy = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      prio      <= SIDE_D;
      owner     <= SIDE_I;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner     <= gnt_side;
            prio      <= ~gnt_side;
            lat_we    <= (gnt_side == SIDE_D) ? d_we : i_we;
            lat_addr  <= (gnt_side == SIDE_D) ? d_addr : i_addr;
            lat_wdata <= (gnt_side == SIDE_D) ? d_wdata : i_wdata;
            cnt       <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (!lat_we) rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side address/data simply expose the latches so they hold between accesses.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_wen   = last_busy && lat_we;

  assign i_ack = (state == DONE) && (owner == SIDE_I);
  assign d_ack = (state == DONE) && (owner == SIDE_D);

  assign clk_lock = ~((i_req & ~i_ack) | (d_req & ~d_ack));

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: default-latency instance plus a MEM_LAT=1
// instance, each with its own behavioural line memory.
module tb_line_mem_arbiter;
  import line_mem_pkg::*;

  localparam int AW  = 12;
  localparam int LW  = 256;
  localparam int LAT = 4;

  typedef struct {
    logic          side;
    logic [LW-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          i_req, i_we, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata;
  logic          i_ack, d_ack, mem_wen, clk_lock;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] rdata, mem_wdata, mem_rdata;
  logic [LW-1:0] mem [0:(1<<AW)-1];

  logic          f_i_req, f_i_we, f_d_req, f_d_we;
  logic [AW-1:0] f_i_addr, f_d_addr;
  logic [LW-1:0] f_i_wdata, f_d_wdata;
  logic          f_i_ack, f_d_ack, f_mem_wen, f_clk_lock;
  logic [AW-1:0] f_mem_addr;
  logic [LW-1:0] f_rdata, f_mem_wdata, f_mem_rdata;
  logic [LW-1:0] f_mem [0:(1<<AW)-1];

  line_mem_arbiter #(.AW(AW), .LW(LW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .clk_lock(clk_lock)
  );

  line_mem_arbiter #(.AW(AW), .LW(LW), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .i_req(f_i_req), .i_we(f_i_we), .i_addr(f_i_addr), .i_wdata(f_i_wdata), .i_ack(f_i_ack),
    .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr), .d_wdata(f_d_wdata), .d_ack(f_d_ack),
    .rdata(f_rdata), .mem_wen(f_mem_wen), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata), .clk_lock(f_clk_lock)
  );

  assign mem_rdata   = mem[mem_addr];
  assign f_mem_rdata = f_mem[f_mem_addr];
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;
  always @(posedge clk) if (f_mem_wen) f_mem[f_mem_addr] <= f_mem_wdata;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {8{32'hC0DE_0000 | {20'h0, a}}};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
  endtask

  // Single access from cycle 0 (the call point, just after an edge) to the ack.
  task automatic access(input logic side, input logic we, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wd, input logic [LW-1:0] exp_rd);
    int   c, ack_c, wen_n, wen_c;
    bit   addr_ok, lock_ok, other_ok;
    exp_t e;
    c = 0; ack_c = -1; wen_n = 0; wen_c = -1;
    addr_ok = 1; lock_ok = 1; other_ok = 1;
    if (side == SIDE_D) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    else begin i_req = 1; i_we = we; i_addr = addr; i_wdata = wd; end
    sb.push_back('{side, exp_rd});
    #1;
    if (clk_lock !== 1'b0) lock_ok = 0;
    while (ack_c < 0 && c < 30) begin
      @(posedge clk); #1; c++;
      if (mem_wen === 1'b1) begin wen_n++; wen_c = c; end
      if (c <= LAT && mem_addr !== addr) addr_ok = 0;
      if (c <= LAT && clk_lock !== 1'b0) lock_ok = 0;
      if ((side == SIDE_D ? i_ack : d_ack) !== 1'b0) other_ok = 0;
      if ((side == SIDE_D ? d_ack : i_ack) === 1'b1) ack_c = c;
    end
    check("ack_cycle", LW'(ack_c), LW'(LAT + 1));
    check("lock_high_at_ack", LW'(clk_lock), LW'(1));
    check("lock_low_busy", LW'(lock_ok), LW'(1));
    check("mem_addr_busy", LW'(addr_ok), LW'(1));
    check("other_ack_quiet", LW'(other_ok), LW'(1));
    check("wen_count", LW'(wen_n), LW'(we ? 1 : 0));
    if (we) check("wen_cycle", LW'(wen_c), LW'(LAT));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rdata", rdata, e.rd);
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
  endtask

  initial begin
    int            c, n_ack, lock_bad;
    bit            wen_seen, ack_seen;
    logic [LW-1:0] last_rd;
    logic [LW-1:0] wpat;
    exp_t          e;

    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]   <= pat(AW'(a));
      f_mem[a] <= pat(AW'(a));
    end
    f_i_req = 0; f_i_we = 0; f_i_addr = '0; f_i_wdata = '0;
    f_d_req = 0; f_d_we = 0; f_d_addr = '0; f_d_wdata = '0;

    // Reset with random non-request inputs.
    idle_inputs();
    i_we = 1'($urandom); d_we = 1'($urandom);
    i_addr = AW'($urandom); d_addr = AW'($urandom);
    i_wdata = {8{$urandom()}}; d_wdata = {8{$urandom()}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_ack", LW'(i_ack), '0);
    check("rst_d_ack", LW'(d_ack), '0);
    check("rst_mem_wen", LW'(mem_wen), '0);
    check("rst_mem_addr", LW'(mem_addr), '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_rdata", rdata, '0);
    check("rst_clk_lock", LW'(clk_lock), LW'(1));
    rst = 1;
    wen_seen = 0; ack_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_wen !== 1'b0) wen_seen = 1;
      if (i_ack !== 1'b0 || d_ack !== 1'b0) ack_seen = 1;
    end
    check("idle_no_activity", LW'({wen_seen, ack_seen}), '0);
    idle_inputs();

    // Single accesses.
    access(SIDE_D, 1'b0, 12'h03A, '0, pat(12'h03A));
    last_rd = pat(12'h03A);
    wpat = {8{32'hDEADBEEF}};
    access(SIDE_I, 1'b1, 12'h100, wpat, last_rd);
    check("mem_written", mem[12'h100], wpat);
    access(SIDE_D, 1'b0, 12'h100, '0, wpat);
    access(SIDE_D, 1'b1, 12'h055, ~pat(12'h055), wpat);
    access(SIDE_I, 1'b0, 12'h055, '0, ~pat(12'h055));

    // Contention: both sides held high, D first after reset.
    reset_pulse();
    @(posedge clk); #1;
    i_req = 1; i_we = 0; i_addr = 12'h011;
    d_req = 1; d_we = 0; d_addr = 12'h022;
    for (int k = 0; k < 4; k++)
      sb.push_back('{(k % 2 == 0) ? SIDE_D : SIDE_I, (k % 2 == 0) ? pat(12'h022) : pat(12'h011)});
    c = 0; n_ack = 0; lock_bad = 0;
    while (n_ack < 4 && c < 40) begin
      @(posedge clk); #1; c++;
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        e = sb.pop_front();
        check("cont_ack_cycle", LW'(c), LW'(5 + 6 * n_ack));
        check("cont_side", LW'(d_ack), LW'(e.side));
        check("cont_rdata", rdata, e.rd);
        n_ack++;
      end else if (clk_lock !== 1'b0) lock_bad++;
    end
    check("cont_ack_count", LW'(n_ack), LW'(4));
    check("cont_lock_low", LW'(lock_bad), '0);
    sb.delete();
    @(posedge clk); #1;
    idle_inputs();

    // Abort: reset lands mid-write, before the strobe cycle.
    reset_pulse();
    @(posedge clk); #1;
    i_req = 1; i_we = 1; i_addr = 12'h200; i_wdata = ~pat(12'h200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    i_req = 0;
    #1;
    check("abort_wen_drop", LW'(mem_wen), '0);
    wen_seen = 0; ack_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst = 1;
      if (mem_wen !== 1'b0) wen_seen = 1;
      if (i_ack !== 1'b0 || d_ack !== 1'b0) ack_seen = 1;
    end
    check("abort_no_wen", LW'(wen_seen), '0);
    check("abort_no_ack", LW'(ack_seen), '0);
    check("abort_mem_kept", mem[12'h200], pat(12'h200));
    check("abort_rdata_reset", rdata, '0);
    idle_inputs();
    access(SIDE_I, 1'b0, 12'h200, '0, pat(12'h200));

    // MEM_LAT=1 instance: held read request, granted every 3 cycles.
    @(posedge clk); #1;
    f_d_req = 1; f_d_addr = 12'h007;
    c = 0; n_ack = 0;
    while (n_ack < 3 && c < 20) begin
      @(posedge clk); #1; c++;
      if (c == 1) begin
        check("lat1_busy_addr", LW'(f_mem_addr), LW'(12'h007));
        check("lat1_lock_low", LW'(f_clk_lock), '0);
      end
      if (f_d_ack === 1'b1) begin
        check("lat1_ack_cycle", LW'(c), LW'(2 + 3 * n_ack));
        if (n_ack == 0) check("lat1_rdata", f_rdata, pat(12'h007));
        n_ack++;
      end
    end
    check("lat1_ack_count", LW'(n_ack), LW'(3));
    @(posedge clk); #1;
    f_d_req = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares the single 256-bit-line data memory between two line requesters: instruction-side refill (I) and data-cache fetch/write-back (D).
- Sequences each memory access over a fixed multi-cycle latency and returns read data plus a one-cycle acknowledge.
- Drives the clk_lock pipeline enable: low while any request is outstanding, so the pipeline freezes until the acknowledge.
- Sits between both caches and data_memory, replacing the direct cache-to-memory connection.

Parameters:
- AW, 12, line address width (matches wb_addr)
- LW, 256, line data width
- MEM_LAT, 4, memory busy cycles per access; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- i_req  in  1  I-side request; held until i_ack
- i_we  in  1  I-side write (1) / read (0); stable while i_req
- i_addr  in  AW  I-side line address
- i_wdata  in  LW  I-side write line
- i_ack  out  1  one-cycle completion pulse to I
- d_req, d_we, d_addr, d_wdata, d_ack  same as I-side, for D
- rdata  out  LW  last read line; valid from ack until the next read completes
- mem_wen  out  1  write strobe to data memory
- mem_addr  out  AW  memory line address
- mem_wdata  out  LW  memory write line
- mem_rdata  in  LW  memory read line (combinational from mem_addr)
- clk_lock  out  1  1 = pipeline may advance

Behaviour:
- Reset (rst=0, asynchronous) gives:
  - state=IDLE, cnt=0, prio=D, owner=I;
  - latched addr, wdata and rdata all 0;
  - i_ack=d_ack=mem_wen=0, mem_addr=0, mem_wdata=0, clk_lock=1.
- FSM states:
  - IDLE: if any req, pick a winner, latch its we/addr/wdata and owner, set cnt=MEM_LAT-1, go to BUSY. Otherwise stay in IDLE.
  - BUSY: mem_addr and mem_wdata are driven from the latched values. cnt decrements each cycle. At cnt==0:
    - if write, mem_wen=1 for exactly that cycle;
    - if read, rdata <= mem_rdata at the end of that cycle;
    - then go to DONE.
  - DONE: assert the owner's ack (the other ack stays 0), go to IDLE.
- Latency: a request first sampled in cycle 0 gives BUSY in cycles 1..MEM_LAT and ack in cycle MEM_LAT+1 (cycle 5 at default). The next grant is sampled no earlier than cycle MEM_LAT+2.
- Arbitration is 2-way round-robin:
  - single request: granted regardless of prio;
  - both requesting: prio side wins;
  - on every grant, prio <= the non-granted side.
- Requester rule: deassert req in the cycle after ack, or re-request. A req still high in IDLE is treated as a new request.
- mem_addr and mem_wdata hold the latched values outside BUSY. mem_wen=0 outside the final BUSY cycle.
- A write leaves rdata unchanged.
- Outputs are registered or state-decoded only, except clk_lock.
- clk_lock = ~((i_req & ~i_ack) | (d_req & ~d_ack)), combinational. It rises in the ack cycle if no other request is pending.
- Req or data changing mid-access is ignored; the latched copy is used.
- Reset mid-access aborts it:
  - no ack is issued;
  - mem_wen drops immediately;
  - a write not yet strobed is never performed.
- MEM_LAT=1: BUSY lasts one cycle, which is also the strobe/capture cycle.

Decomposition:
- Shared package line_mem_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - AW/LW defaults;
  - SIDE_I=1'b0, SIDE_D=1'b1.
- One sub-module, rr_arb2: combinational two-requester round-robin pick (inputs req_i, req_d, prio; outputs gnt_valid, gnt_side).
- The FSM, counter, latches and rdata register live in line_mem_arbiter.

Test Plan:
- Reset: rst=0 with random inputs -> all acks/mem_wen 0, clk_lock=1, rdata=0. Release rst -> IDLE, no activity without req.
- Single read: memory preloaded line 0x3A = pattern P; d_req=1, d_we=0, d_addr=12'h03A in cycle 0 ->
  - mem_addr=0x03A in cycles 1-4;
  - d_ack=1 in cycle 5 only, rdata=P;
  - clk_lock=0 in cycles 0-4, 1 in cycle 5.
- Single write: i_req=1, i_we=1, i_addr=12'h100, i_wdata={8{32'hDEADBEEF}} ->
  - mem_wen=1 in cycle 4 only, i_ack cycle 5;
  - a later read of 0x100 returns the same pattern.
- Contention: i_req and d_req both raised in cycle 0 and held, re-requesting after each ack ->
  - grants alternate D, I, D, I, with D first after reset;
  - acks at cycles 5, 11, 17, 23.
- Abort: a write is issued, rst pulsed low in cycle 2 ->
  - mem_wen never asserted, no ack;
  - memory line unchanged;
  - after release, a fresh request completes normally.
- MEM_LAT=1 build: read request in cycle 0 -> BUSY cycle 1, ack cycle 2, rdata correct; back-to-back requests are granted every 3 cycles.
